// File: rtl/tl_async_crossing_source.sv
// Purpose: source end of a TileLink async crossing; A requests go into a depth-1 async slot, D responses are drained from the far slot.
// Latency: A slot/widx update at the accepting edge; D valid appears SYNC_STAGES+1 edges after a far widx toggle.
// Backpressure: a_ready is low while the A slot is unacknowledged or the link is down; D output register holds until auto_in_d_ready.
// Optional: define TL_ASYNC_SRC_SAFE_EN for the full safe reset/valid handshake; otherwise safe_* outputs are tied high and safe_* inputs ignored.
module tl_async_crossing_source #(
   parameter int SYNC_STAGES = 3  // legal range 2..4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [8:0]  auto_in_a_bits_address,
   input  logic [31:0] auto_in_a_bits_data,
   output logic [2:0]  auto_out_a_mem_0_opcode,
   output logic [8:0]  auto_out_a_mem_0_address,
   output logic [31:0] auto_out_a_mem_0_data,
   output logic        auto_out_a_widx,
   input  logic        auto_out_a_ridx,
   output logic        auto_out_a_safe_widx_valid,
   input  logic        auto_out_a_safe_ridx_valid,
   output logic        auto_out_a_safe_source_reset_n,
   input  logic        auto_out_a_safe_sink_reset_n,
   input  logic [2:0]  auto_out_d_mem_0_opcode,
   input  logic [1:0]  auto_out_d_mem_0_size,
   input  logic        auto_out_d_mem_0_source,
   input  logic [31:0] auto_out_d_mem_0_data,
   input  logic        auto_out_d_widx,
   output logic        auto_out_d_ridx,
   input  logic        auto_out_d_safe_widx_valid,
   output logic        auto_out_d_safe_ridx_valid,
   input  logic        auto_out_d_safe_source_reset_n,
   output logic        auto_out_d_safe_sink_reset_n,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_size,
   output logic        auto_in_d_bits_source,
   output logic [31:0] auto_in_d_bits_data
);

   typedef struct packed {
      logic [2:0]  opcode;
      logic [8:0]  address;
      logic [31:0] data;
   } a_req_t;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic        source;
      logic [31:0] data;
   } d_rsp_t;

   localparam int SYNC_W = 6;

   logic [SYNC_W-1:0] sync_in;
   logic [SYNC_W-1:0] sync_out;
   logic [SYNC_W-1:0] sync_q [SYNC_STAGES];

   logic a_ridx_s, a_sink_rst_s, a_ridx_valid_s;
   logic d_widx_s, d_src_rst_s, d_widx_valid_s;

   logic a_link_ok, d_link_ok, link_ok;
   logic local_ok, local_ok_next;

   a_req_t a_in, a_mem_q;
   d_rsp_t d_in, d_bits_q;
   logic   widx_q, widx_next, a_ready_q, a_fire;
   logic   ridx_q, d_valid_q, d_pending;

   assign sync_in = {auto_out_a_ridx, auto_out_a_safe_sink_reset_n, auto_out_a_safe_ridx_valid,
                     auto_out_d_widx, auto_out_d_safe_source_reset_n, auto_out_d_safe_widx_valid};

   // Synchronizer chains for every far-domain signal; left unreset so they track the far side through a local reset
   always_ff @(posedge clock) begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign {a_ridx_s, a_sink_rst_s, a_ridx_valid_s, d_widx_s, d_src_rst_s, d_widx_valid_s} = sync_out;

`ifdef TL_ASYNC_SRC_SAFE_EN
   logic local_up_q;
   logic idx_valid_q;

   // Local reset release: announce reset_n at the first edge, index-valid one edge later
   always_ff @(posedge clock) begin
      if (reset) begin
         local_up_q  <= 1'b0;
         idx_valid_q <= 1'b0;
      end else begin
         local_up_q  <= 1'b1;
         idx_valid_q <= local_up_q;
      end
   end

   assign a_link_ok     = a_sink_rst_s & a_ridx_valid_s;
   assign d_link_ok     = d_src_rst_s & d_widx_valid_s;
   assign local_ok      = idx_valid_q;
   assign local_ok_next = local_up_q;

   assign auto_out_a_safe_source_reset_n = local_up_q;
   assign auto_out_d_safe_sink_reset_n   = local_up_q;
   assign auto_out_a_safe_widx_valid     = idx_valid_q;
   assign auto_out_d_safe_ridx_valid     = idx_valid_q;
`else
   logic unused_safe;

   assign a_link_ok     = 1'b1;
   assign d_link_ok     = 1'b1;
   assign local_ok      = 1'b1;
   assign local_ok_next = 1'b1;

   assign auto_out_a_safe_source_reset_n = 1'b1;
   assign auto_out_d_safe_sink_reset_n   = 1'b1;
   assign auto_out_a_safe_widx_valid     = 1'b1;
   assign auto_out_d_safe_ridx_valid     = 1'b1;

   assign unused_safe = ^{a_sink_rst_s, a_ridx_valid_s, d_src_rst_s, d_widx_valid_s};
`endif

   // A far reset on either direction collapses both queues back to index 0
   assign link_ok = a_link_ok & d_link_ok;

   // ---------------- A queue source ----------------
   assign a_in   = {auto_in_a_bits_opcode, auto_in_a_bits_address, auto_in_a_bits_data};
   assign a_fire = auto_in_a_valid & a_ready_q;

   // Next write index: forced to 0 while the link is down, otherwise toggles on each accepted request
   always_comb begin
      widx_next = widx_q;
      if (!link_ok) begin
         widx_next = 1'b0;
      end else if (a_fire) begin
         widx_next = ~widx_q;
      end
   end

   // A slot state; ready is registered from the post-edge index so it drops at the accepting edge
   // and rises one edge after the synchronized read index catches up
   always_ff @(posedge clock) begin
      if (reset) begin
         widx_q    <= 1'b0;
         a_ready_q <= 1'b0;
         a_mem_q   <= '0;
      end else begin
         widx_q    <= widx_next;
         a_ready_q <= (widx_next == a_ridx_s) & link_ok & local_ok_next;
         if (a_fire) begin
            a_mem_q <= a_in;
         end
      end
   end

   assign auto_in_a_ready          = a_ready_q;
   assign auto_out_a_widx          = widx_q;
   assign auto_out_a_mem_0_opcode  = a_mem_q.opcode;
   assign auto_out_a_mem_0_address = a_mem_q.address;
   assign auto_out_a_mem_0_data    = a_mem_q.data;

   // ---------------- D queue sink ----------------
   assign d_in      = {auto_out_d_mem_0_opcode, auto_out_d_mem_0_size, auto_out_d_mem_0_source, auto_out_d_mem_0_data};
   assign d_pending = (d_widx_s != ridx_q) & d_link_ok & local_ok;

   // D output register: refill whenever the register is free or being consumed, so back-to-back responses have no bubble
   always_ff @(posedge clock) begin
      if (reset) begin
         ridx_q    <= 1'b0;
         d_valid_q <= 1'b0;
         d_bits_q  <= '0;
      end else if (!link_ok) begin
         ridx_q    <= 1'b0;
         d_valid_q <= 1'b0;
      end else if (d_pending && (!d_valid_q || auto_in_d_ready)) begin
         d_bits_q  <= d_in;
         d_valid_q <= 1'b1;
         ridx_q    <= ~ridx_q;
      end else if (auto_in_d_ready) begin
         d_valid_q <= 1'b0;
      end
   end

   assign auto_out_d_ridx       = ridx_q;
   assign auto_in_d_valid       = d_valid_q;
   assign auto_in_d_bits_opcode = d_bits_q.opcode;
   assign auto_in_d_bits_size   = d_bits_q.size;
   assign auto_in_d_bits_source = d_bits_q.source;
   assign auto_in_d_bits_data   = d_bits_q.data;

endmodule

// File: tb/tb_tl_async_crossing_source.sv
// Bench for tl_async_crossing_source: directed stimulus with expected A-slot and D-response queues.
// Monitors pop and compare whenever an A request is accepted or a D response is consumed.
// Follows TL_ASYNC_SRC_SAFE_EN to pick the reset-release and far-reset expectations.
module tb_tl_async_crossing_source;

   localparam int SYNC_STAGES = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        auto_in_a_ready;
   logic        auto_in_a_valid = 1'b0;
   logic [2:0]  auto_in_a_bits_opcode = '0;
   logic [8:0]  auto_in_a_bits_address = '0;
   logic [31:0] auto_in_a_bits_data = '0;
   logic [2:0]  auto_out_a_mem_0_opcode;
   logic [8:0]  auto_out_a_mem_0_address;
   logic [31:0] auto_out_a_mem_0_data;
   logic        auto_out_a_widx;
   logic        auto_out_a_ridx = 1'b0;
   logic        auto_out_a_safe_widx_valid;
   logic        auto_out_a_safe_ridx_valid = 1'b1;
   logic        auto_out_a_safe_source_reset_n;
   logic        auto_out_a_safe_sink_reset_n = 1'b1;
   logic [2:0]  auto_out_d_mem_0_opcode = '0;
   logic [1:0]  auto_out_d_mem_0_size = '0;
   logic        auto_out_d_mem_0_source = 1'b0;
   logic [31:0] auto_out_d_mem_0_data = '0;
   logic        auto_out_d_widx = 1'b0;
   logic        auto_out_d_ridx;
   logic        auto_out_d_safe_widx_valid = 1'b1;
   logic        auto_out_d_safe_ridx_valid;
   logic        auto_out_d_safe_source_reset_n = 1'b1;
   logic        auto_out_d_safe_sink_reset_n;
   logic        auto_in_d_ready = 1'b0;
   logic        auto_in_d_valid;
   logic [2:0]  auto_in_d_bits_opcode;
   logic [1:0]  auto_in_d_bits_size;
   logic        auto_in_d_bits_source;
   logic [31:0] auto_in_d_bits_data;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [8:0]  address;
      logic [31:0] data;
      logic        widx;
   } a_exp_t;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic        source;
      logic [31:0] data;
   } d_exp_t;

   a_exp_t a_q[$];
   d_exp_t d_q[$];
   int     checks = 0;
   int     errors = 0;
   bit     a_armed = 1'b0;

`ifdef TL_ASYNC_SRC_SAFE_EN
   localparam bit SAFE = 1'b1;
`else
   localparam bit SAFE = 1'b0;
`endif

   tl_async_crossing_source #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clock                          (clock),
      .reset                          (reset),
      .auto_in_a_ready                (auto_in_a_ready),
      .auto_in_a_valid                (auto_in_a_valid),
      .auto_in_a_bits_opcode          (auto_in_a_bits_opcode),
      .auto_in_a_bits_address         (auto_in_a_bits_address),
      .auto_in_a_bits_data            (auto_in_a_bits_data),
      .auto_out_a_mem_0_opcode        (auto_out_a_mem_0_opcode),
      .auto_out_a_mem_0_address       (auto_out_a_mem_0_address),
      .auto_out_a_mem_0_data          (auto_out_a_mem_0_data),
      .auto_out_a_widx                (auto_out_a_widx),
      .auto_out_a_ridx                (auto_out_a_ridx),
      .auto_out_a_safe_widx_valid     (auto_out_a_safe_widx_valid),
      .auto_out_a_safe_ridx_valid     (auto_out_a_safe_ridx_valid),
      .auto_out_a_safe_source_reset_n (auto_out_a_safe_source_reset_n),
      .auto_out_a_safe_sink_reset_n   (auto_out_a_safe_sink_reset_n),
      .auto_out_d_mem_0_opcode        (auto_out_d_mem_0_opcode),
      .auto_out_d_mem_0_size          (auto_out_d_mem_0_size),
      .auto_out_d_mem_0_source        (auto_out_d_mem_0_source),
      .auto_out_d_mem_0_data          (auto_out_d_mem_0_data),
      .auto_out_d_widx                (auto_out_d_widx),
      .auto_out_d_ridx                (auto_out_d_ridx),
      .auto_out_d_safe_widx_valid     (auto_out_d_safe_widx_valid),
      .auto_out_d_safe_ridx_valid     (auto_out_d_safe_ridx_valid),
      .auto_out_d_safe_source_reset_n (auto_out_d_safe_source_reset_n),
      .auto_out_d_safe_sink_reset_n   (auto_out_d_safe_sink_reset_n),
      .auto_in_d_ready                (auto_in_d_ready),
      .auto_in_d_valid                (auto_in_d_valid),
      .auto_in_d_bits_opcode          (auto_in_d_bits_opcode),
      .auto_in_d_bits_size            (auto_in_d_bits_size),
      .auto_in_d_bits_source          (auto_in_d_bits_source),
      .auto_in_d_bits_data            (auto_in_d_bits_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one edge; inputs are driven and outputs checked 1 time unit after it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] dat, input logic exp_widx);
      auto_in_a_valid        = 1'b1;
      auto_in_a_bits_opcode  = op;
      auto_in_a_bits_address = addr;
      auto_in_a_bits_data    = dat;
      a_q.push_back('{op, addr, dat, exp_widx});
   endtask

   task automatic drive_d(input logic [2:0] op, input logic [1:0] sz, input logic src, input logic [31:0] dat, input logic widx);
      auto_out_d_mem_0_opcode = op;
      auto_out_d_mem_0_size   = sz;
      auto_out_d_mem_0_source = src;
      auto_out_d_mem_0_data   = dat;
      auto_out_d_widx         = widx;
      d_q.push_back('{op, sz, src, dat});
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!auto_in_a_ready && n < 20) begin
         tick();
         n++;
      end
      check(name, auto_in_a_ready, 1);
   endtask

   // Scoreboard monitors: A slot checked the cycle after an accept, D bits checked at each consume
   always @(negedge clock) begin
      if (a_armed) begin
         if (a_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_sb_underflow: accept seen, none expected at %0t", $time);
         end else begin
            a_exp_t e;
            e = a_q.pop_front();
            check("a_mem_opcode", auto_out_a_mem_0_opcode, e.opcode);
            check("a_mem_address", auto_out_a_mem_0_address, e.address);
            check("a_mem_data", auto_out_a_mem_0_data, e.data);
            check("a_widx_after_fire", auto_out_a_widx, e.widx);
         end
      end
      a_armed = auto_in_a_valid && auto_in_a_ready;
      if (auto_in_d_valid && auto_in_d_ready) begin
         if (d_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d_sb_underflow: response seen, none expected at %0t", $time);
         end else begin
            d_exp_t e;
            e = d_q.pop_front();
            check("d_opcode", auto_in_d_bits_opcode, e.opcode);
            check("d_size", auto_in_d_bits_size, e.size);
            check("d_source", auto_in_d_bits_source, e.source);
            check("d_data", auto_in_d_bits_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (5) tick();
      check("rst_a_ready", auto_in_a_ready, 0);
      check("rst_a_widx", auto_out_a_widx, 0);
      check("rst_a_mem", {auto_out_a_mem_0_opcode, auto_out_a_mem_0_address, auto_out_a_mem_0_data[19:0]}, 0);
      check("rst_d_ridx", auto_out_d_ridx, 0);
      check("rst_d_valid", auto_in_d_valid, 0);
      check("rst_d_bits", auto_in_d_bits_data, 0);
      check("rst_safe_out", {auto_out_a_safe_source_reset_n, auto_out_d_safe_sink_reset_n,
                             auto_out_a_safe_widx_valid, auto_out_d_safe_ridx_valid}, SAFE ? 4'h0 : 4'hf);

      // Reset release
      reset = 1'b0;
      tick();
      check("rel1_safe_reset_n", {auto_out_a_safe_source_reset_n, auto_out_d_safe_sink_reset_n}, 2'b11);
      check("rel1_safe_valid", {auto_out_a_safe_widx_valid, auto_out_d_safe_ridx_valid}, SAFE ? 2'b00 : 2'b11);
      check("rel1_a_ready", auto_in_a_ready, SAFE ? 0 : 1);
      tick();
      check("rel2_safe_valid", {auto_out_a_safe_widx_valid, auto_out_d_safe_ridx_valid}, 2'b11);
      check("rel2_a_ready", auto_in_a_ready, 1);
      check("rel2_widx", auto_out_a_widx, 0);
      check("rel2_d_valid", auto_in_d_valid, 0);

      // A fire and slot-full hold until the far read index echoes
      drive_a(3'd4, 9'h1A0, 32'hDEADBEEF, 1'b1);
      tick();
      auto_in_a_valid = 1'b0;
      check("a_ready_after_fire", auto_in_a_ready, 0);
      check("a_widx_fire1", auto_out_a_widx, 1);
      repeat (3) begin
         tick();
         check("a_full_hold", auto_in_a_ready, 0);
      end
      auto_out_a_ridx = 1'b1;
      repeat (SYNC_STAGES) begin
         tick();
         check("a_ready_pre_echo", auto_in_a_ready, 0);
      end
      tick();
      check("a_ready_echo_lat", auto_in_a_ready, 1);

      // D response latency
      drive_d(3'd1, 2'd2, 1'b1, 32'h12345678, 1'b1);
      repeat (SYNC_STAGES) begin
         tick();
         check("d_valid_early", auto_in_d_valid, 0);
      end
      tick();
      check("d_valid_lat", auto_in_d_valid, 1);
      check("d_ridx_toggle", auto_out_d_ridx, 1);

      // D held under backpressure while a second response waits, then no-bubble refill
      drive_d(3'd0, 2'd3, 1'b0, 32'hCAFEF00D, 1'b0);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("d_hold_ridx", auto_out_d_ridx, 1);
         check("d_hold_data", auto_in_d_bits_data, 32'h12345678);
         check("d_hold_valid", auto_in_d_valid, 1);
      end
      auto_in_d_ready = 1'b1;
      tick();
      check("d_no_bubble", auto_in_d_valid, 1);
      check("d_ridx_second", auto_out_d_ridx, 0);
      check("d_second_data", auto_in_d_bits_data, 32'hCAFEF00D);
      tick();
      auto_in_d_ready = 1'b0;
      check("d_drain", auto_in_d_valid, 0);

      // Two more A round trips, then far sink reset with a held request
      drive_a(3'd1, 9'h055, 32'h0BADF00D, 1'b0);
      tick();
      auto_in_a_valid = 1'b0;
      check("a_widx_fire2", auto_out_a_widx, 0);
      auto_out_a_ridx = 1'b0;
      wait_ready("a_ready_wait");
      drive_a(3'd2, 9'h1FF, 32'h5A5A5A5A, 1'b1);
      tick();
      auto_in_a_valid = 1'b0;
      check("a_widx_fire3", auto_out_a_widx, 1);

      auto_out_a_safe_sink_reset_n = 1'b0;
      drive_a(3'd6, 9'h0C3, 32'h01234567, SAFE ? 1'b1 : 1'b0);
      repeat (SYNC_STAGES) begin
         tick();
         check("far_rst_widx_hold", auto_out_a_widx, 1);
         check("far_rst_ready", auto_in_a_ready, 0);
      end
      tick();
      check("far_rst_widx", auto_out_a_widx, SAFE ? 0 : 1);
      check("far_rst_ready_low", auto_in_a_ready, 0);
      repeat (2) begin
         tick();
         check("far_rst_held", auto_in_a_ready, 0);
      end
      auto_out_a_safe_sink_reset_n = 1'b1;
      if (!SAFE) auto_out_a_ridx = 1'b1;
      repeat (SYNC_STAGES) begin
         tick();
         check("recover_ready_early", auto_in_a_ready, 0);
      end
      tick();
      check("recover_ready", auto_in_a_ready, 1);
      tick();
      auto_in_a_valid = 1'b0;
      check("held_req_fired", auto_out_a_widx, SAFE ? 1 : 0);

      repeat (3) tick();
      check("a_sb_empty", a_q.size(), 0);
      check("d_sb_empty", d_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
